// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS main control: opcodes, state codes,
// and the mux-select / ALU-op codes driven toward the datapath.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTYPEEX = 4'd6,
    S_RTYPEWB = 4'd7,
    S_BEQEX   = 4'd8,
    S_JEX     = 4'd9,
    S_ADDIEX  = 4'd10,
    S_ADDIWB  = 4'd11
  } state_t;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_B       = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  function automatic logic op_supported(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
           (op == OP_BEQ) || (op == OP_J) || (op == OP_ADDI);
  endfunction

endpackage

// File: rtl/mips_ctrl_outdec.sv
// Combinational control-strobe decode from the current state and memory ack.
// Reset forces every strobe low so nothing is written in the reset cycle.
module mips_ctrl_outdec
  import mips_ctrl_pkg::*;
(
  input  logic [3:0] state,
  input  logic       mem_ready,
  input  logic       reset,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSource,
  output logic [1:0] OpALU,
  output logic       instr_done
);

  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemtoReg    = 1'b0;
    RegDst      = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = SRCB_B;
    PCSource    = PCSRC_ALU;
    OpALU       = ALUOP_ADD;
    instr_done  = 1'b0;
    if (!reset) begin
      case (state)
        S_FETCH: begin
          MemRead = 1'b1;
          ALUSrcB = SRCB_FOUR;
          IRWrite = mem_ready;
          PCWrite = mem_ready;
        end
        S_DECODE:  ALUSrcB = SRCB_IMM_SH2;
        S_MEMADR: begin
          ALUSrcA = 1'b1;
          ALUSrcB = SRCB_IMM;
        end
        S_MEMRD: begin
          MemRead = 1'b1;
          IorD    = 1'b1;
        end
        S_MEMWB: begin
          MemtoReg   = 1'b1;
          RegWrite   = 1'b1;
          instr_done = 1'b1;
        end
        S_MEMWR: begin
          MemWrite   = 1'b1;
          IorD       = 1'b1;
          instr_done = mem_ready;
        end
        S_RTYPEEX: begin
          ALUSrcA = 1'b1;
          OpALU   = ALUOP_FUNCT;
        end
        S_RTYPEWB: begin
          RegDst     = 1'b1;
          RegWrite   = 1'b1;
          instr_done = 1'b1;
        end
        S_BEQEX: begin
          ALUSrcA     = 1'b1;
          OpALU       = ALUOP_SUB;
          PCWriteCond = 1'b1;
          PCSource    = PCSRC_ALUOUT;
          instr_done  = 1'b1;
        end
        S_JEX: begin
          PCWrite    = 1'b1;
          PCSource   = PCSRC_JUMP;
          instr_done = 1'b1;
        end
        S_ADDIEX: begin
          ALUSrcA = 1'b1;
          ALUSrcB = SRCB_IMM;
        end
        S_ADDIWB: begin
          RegWrite   = 1'b1;
          instr_done = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/mips_main_control.sv
// Multicycle MIPS main control: state register, next-state sequencing and
// illegal-opcode detection; strobes are decoded in mips_ctrl_outdec.
//
// state     | meaning
// FETCH     | read instruction at PC, PC+4; wait for mem_ready
// DECODE    | branch target precompute, dispatch on opcode
// MEMADR    | effective address for lw/sw
// MEMRD     | data read; wait for mem_ready
// MEMWB     | load result to rt
// MEMWR     | data write; wait for mem_ready
// RTYPEEX   | ALU op selected by funct
// RTYPEWB   | ALU result to rd
// BEQEX     | compare and conditional PC load
// JEX       | jump target to PC
// ADDIEX    | A + signext imm
// ADDIWB    | ALU result to rt
module mips_main_control
  import mips_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSource,
  output logic [1:0] OpALU,
  output logic       instr_done,
  output logic       illegal_op,
  output logic [3:0] state
);

  state_t state_q, state_d;

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:   if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        if ((opcode == OP_LW) || (opcode == OP_SW)) state_d = S_MEMADR;
        else if (opcode == OP_RTYPE)                state_d = S_RTYPEEX;
        else if (opcode == OP_BEQ)                  state_d = S_BEQEX;
        else if (opcode == OP_J)                    state_d = S_JEX;
        else if (opcode == OP_ADDI)                 state_d = S_ADDIEX;
        else                                        state_d = S_FETCH;
      end
      S_MEMADR:  state_d = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:   if (mem_ready) state_d = S_MEMWB;
      S_MEMWR:   if (mem_ready) state_d = S_FETCH;
      S_RTYPEEX: state_d = S_RTYPEWB;
      S_ADDIEX:  state_d = S_ADDIWB;
      default:   state_d = S_FETCH;
    endcase
  end

  assign illegal_op = !reset && (state_q == S_DECODE) && !op_supported(opcode);
  assign state      = reset ? 4'd0 : state_q;

  mips_ctrl_outdec u_outdec (
    .state       (state_q),
    .mem_ready   (mem_ready),
    .reset       (reset),
    .PCWrite     (PCWrite),
    .PCWriteCond (PCWriteCond),
    .IorD        (IorD),
    .MemRead     (MemRead),
    .MemWrite    (MemWrite),
    .IRWrite     (IRWrite),
    .MemtoReg    (MemtoReg),
    .RegDst      (RegDst),
    .RegWrite    (RegWrite),
    .ALUSrcA     (ALUSrcA),
    .ALUSrcB     (ALUSrcB),
    .PCSource    (PCSource),
    .OpALU       (OpALU),
    .instr_done  (instr_done)
  );

endmodule

// File: tb/tb_mips_main_control.sv
// Self-checking bench for mips_main_control: per-cycle expected state and
// strobe vector are queued at drive time and compared at the following negedge.
module tb_mips_main_control;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic       MemtoReg, RegDst, RegWrite, ALUSrcA, instr_done, illegal_op;
  logic [1:0] ALUSrcB, PCSource, OpALU;
  logic [3:0] state;

  int total = 0;
  int bad   = 0;
  int ncyc  = 0;
  int done_cnt = 0;
  int ill_cnt  = 0;
  int mw_cnt   = 0;

  typedef struct {
    logic [3:0]  st;
    logic [18:0] outs;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  mips_main_control dut (
    .clk         (clk),
    .reset       (reset),
    .opcode      (opcode),
    .mem_ready   (mem_ready),
    .PCWrite     (PCWrite),
    .PCWriteCond (PCWriteCond),
    .IorD        (IorD),
    .MemRead     (MemRead),
    .MemWrite    (MemWrite),
    .IRWrite     (IRWrite),
    .MemtoReg    (MemtoReg),
    .RegDst      (RegDst),
    .RegWrite    (RegWrite),
    .ALUSrcA     (ALUSrcA),
    .ALUSrcB     (ALUSrcB),
    .PCSource    (PCSource),
    .OpALU       (OpALU),
    .instr_done  (instr_done),
    .illegal_op  (illegal_op),
    .state       (state)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Expected strobes straight from the state table; bit order matches obs_vec.
  function automatic logic [18:0] exp_vec(input int st, input logic mr,
                                          input logic [5:0] op, input logic rst);
    logic pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, srca, done, ill;
    logic [1:0] srcb, pcs, aop;
    {pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, srca, done, ill} = '0;
    srcb = 2'b00; pcs = 2'b00; aop = 2'b00;
    if (!rst) begin
      case (st)
        0:  begin mrd = 1; srcb = 2'b01; irw = mr; pcw = mr; end
        1:  begin
              srcb = 2'b11;
              ill = !(op == 6'b100011 || op == 6'b101011 || op == 6'b000000 ||
                      op == 6'b000100 || op == 6'b000010 || op == 6'b001000);
            end
        2:  begin srca = 1; srcb = 2'b10; end
        3:  begin mrd = 1; iord = 1; end
        4:  begin m2r = 1; rw = 1; done = 1; end
        5:  begin mwr = 1; iord = 1; done = mr; end
        6:  begin srca = 1; aop = 2'b10; end
        7:  begin rdst = 1; rw = 1; done = 1; end
        8:  begin srca = 1; aop = 2'b01; pcwc = 1; pcs = 2'b01; done = 1; end
        9:  begin pcw = 1; pcs = 2'b10; done = 1; end
        10: begin srca = 1; srcb = 2'b10; end
        11: begin rw = 1; done = 1; end
        default: ;
      endcase
    end
    return {pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, srca, srcb, pcs, aop, done, ill};
  endfunction

  function automatic logic [18:0] obs_vec();
    return {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst,
            RegWrite, ALUSrcA, ALUSrcB, PCSource, OpALU, instr_done, illegal_op};
  endfunction

  // One clock cycle: drive inputs, queue the expectation, compare at negedge.
  task automatic step(input int st, input logic mr, input logic rst);
    exp_t e, got;
    reset     = rst;
    mem_ready = mr;
    e.st   = rst ? 4'd0 : 4'(st);
    e.outs = exp_vec(st, mr, opcode, rst);
    sb.push_back(e);
    @(negedge clk);
    ncyc++;
    if (sb.size() == 0) begin
      chk($sformatf("cyc%0d_sb_empty", ncyc), 32'd1, 32'd0);
    end else begin
      got = sb.pop_front();
      chk($sformatf("cyc%0d_state", ncyc), 32'(state), 32'(got.st));
      chk($sformatf("cyc%0d_outs_st%0d", ncyc, got.st), 32'(obs_vec()), 32'(got.outs));
    end
    if (instr_done === 1'b1) done_cnt++;
    if (illegal_op === 1'b1) ill_cnt++;
    if (MemWrite   === 1'b1) mw_cnt++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; opcode = 6'b000000; mem_ready = 1'b0;
    @(posedge clk); #1;
    step(0, 0, 1); step(0, 1, 1);

    opcode = 6'b100011;               // lw, no waits
    step(0, 1, 0); step(1, 1, 0); step(2, 1, 0); step(3, 1, 0); step(4, 1, 0);
    chk("lw_done", 32'(done_cnt), 32'd1);

    opcode = 6'b000000;               // R-type
    step(0, 1, 0); step(1, 1, 0); step(6, 1, 0); step(7, 1, 0);

    opcode = 6'b000100;               // beq
    step(0, 1, 0); step(1, 1, 0); step(8, 1, 0);

    opcode = 6'b101011;               // sw, three wait cycles in MEMWR
    mw_cnt = 0;
    step(0, 1, 0); step(1, 1, 0); step(2, 1, 0);
    step(5, 0, 0); step(5, 0, 0); step(5, 0, 0); step(5, 1, 0);
    chk("sw_memwrite_cycles", 32'(mw_cnt), 32'd4);

    opcode = 6'b001000;               // addi with one fetch wait
    step(0, 0, 0); step(0, 1, 0); step(1, 0, 0); step(10, 0, 0); step(11, 1, 0);

    opcode = 6'b000010;               // j
    step(0, 1, 0); step(1, 1, 0); step(9, 1, 0);

    opcode = 6'b111111;               // unsupported
    step(0, 1, 0); step(1, 1, 0);
    chk("illegal_pulses", 32'(ill_cnt), 32'd1);

    opcode = 6'b100011;               // lw aborted by reset during MEMRD wait
    step(0, 1, 0); step(1, 1, 0); step(2, 1, 0); step(3, 0, 0);
    step(3, 0, 1);

    opcode = 6'b000010;               // clean restart
    step(0, 1, 0); step(1, 1, 0); step(9, 1, 0); step(0, 0, 0);

    chk("instr_done_total", 32'(done_cnt), 32'd7);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
